// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared types, widths and saturating helpers for the LED PWM driver
package led_pwm_pkg;

  localparam int PWM_W = 8;
  localparam logic [PWM_W-1:0] MAX_LEVEL = 8'd255;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } led_state_t;

  // One extra bit catches the carry/borrow so the level clamps instead of wrapping.
  function automatic logic [PWM_W-1:0] sat_add(input logic [PWM_W-1:0] a,
                                               input logic [PWM_W-1:0] b);
    logic [PWM_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[PWM_W] ? MAX_LEVEL : sum[PWM_W-1:0];
  endfunction

  function automatic logic [PWM_W-1:0] sat_sub(input logic [PWM_W-1:0] a,
                                               input logic [PWM_W-1:0] b);
    logic [PWM_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[PWM_W] ? '0 : diff[PWM_W-1:0];
  endfunction

endpackage

// File: rtl/led_ramp_channel.sv
// rtl/led_ramp_channel.sv - one LED channel: fade FSM, brightness level and PWM compare
module led_ramp_channel
  import led_pwm_pkg::*;
#(
  parameter int STEP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tick,
  input  logic             req,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             pwm,
  output logic             active_next
);

  localparam logic [PWM_W-1:0] STEP_V = PWM_W'(STEP);

  led_state_t       state;
  led_state_t       state_d;
  logic [PWM_W-1:0] level;
  logic [PWM_W-1:0] level_d;

  // A request change wins over a coincident tick: direction flips, level is kept.
  always_comb begin
    state_d = state;
    level_d = level;
    if (en) begin
      case (state)
        ST_OFF: begin
          if (req) state_d = ST_UP;
        end
        ST_UP: begin
          if (!req) begin
            state_d = ST_DOWN;
          end else if (tick) begin
            level_d = sat_add(level, STEP_V);
            if (level_d == MAX_LEVEL) state_d = ST_ON;
          end
        end
        ST_ON: begin
          if (!req) state_d = ST_DOWN;
        end
        ST_DOWN: begin
          if (req) begin
            state_d = ST_UP;
          end else if (tick) begin
            level_d = sat_sub(level, STEP_V);
            if (level_d == '0) state_d = ST_OFF;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  assign active_next = (state_d == ST_UP) || (state_d == ST_DOWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
      level <= '0;
      pwm   <= 1'b0;
    end else begin
      state <= state_d;
      level <= level_d;
      // Full brightness is forced solid; pwm_cnt never exceeds 255 so '>' alone would leave a gap.
      pwm   <= en && ((level == MAX_LEVEL) || (level > pwm_cnt));
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - three-channel LED fader: shared PWM counter and ramp prescaler
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int RAMP_DIV = 4,
  parameter int STEP     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] led_in,
  input  logic       en,
  output logic [2:0] led_pwm,
  output logic       busy
);

  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);

  logic [2:0]       led_q;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PRE_W-1:0] prescaler;
  logic             tick;
  logic [2:0]       active_next;

  assign tick = en && (prescaler == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= '0;
      pwm_cnt   <= '0;
      prescaler <= '0;
      busy      <= 1'b0;
    end else begin
      led_q <= led_in;
      busy  <= |active_next;
      // Counters simply stall while disabled so resuming keeps the PWM and ramp phase.
      if (en) begin
        pwm_cnt   <= pwm_cnt + PWM_W'(1);
        prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      end
    end
  end

  led_ramp_channel #(.STEP(STEP)) u_ch0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .tick        (tick),
    .req         (led_q[0]),
    .pwm_cnt     (pwm_cnt),
    .pwm         (led_pwm[0]),
    .active_next (active_next[0])
  );

  led_ramp_channel #(.STEP(STEP)) u_ch1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .tick        (tick),
    .req         (led_q[1]),
    .pwm_cnt     (pwm_cnt),
    .pwm         (led_pwm[1]),
    .active_next (active_next[1])
  );

  led_ramp_channel #(.STEP(STEP)) u_ch2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .tick        (tick),
    .req         (led_q[2]),
    .pwm_cnt     (pwm_cnt),
    .pwm         (led_pwm[2]),
    .active_next (active_next[2])
  );

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - directed self-checking bench for led_pwm_driver
module tb_led_pwm_driver;
  import led_pwm_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] led_in;
  logic       en;
  logic [2:0] led_pwm;
  logic       busy;
  logic [2:0] fast_pwm;
  logic       fast_busy;
  logic [2:0] slow_pwm;
  logic       slow_busy;

  int n_checks;
  int n_fail;
  int edge_n;

  led_pwm_driver dut (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .en(en), .led_pwm(led_pwm), .busy(busy)
  );

  led_pwm_driver #(.RAMP_DIV(1), .STEP(255)) dut_fast (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .en(en), .led_pwm(fast_pwm), .busy(fast_busy)
  );

  led_pwm_driver #(.RAMP_DIV(256), .STEP(128)) dut_slow (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .en(en), .led_pwm(slow_pwm), .busy(slow_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input logic [2:0] li, input logic e);
    rst_n  = 1'b0;
    led_in = li;
    en     = e;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic run_to(input int k);
    while (edge_n < k) begin
      @(negedge clk);
      edge_n++;
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    led_in = 3'b111;
    en     = 1'b1;
    #1;
    n_checks++;
    if ({led_pwm, busy, fast_pwm, fast_busy} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b %b %b %b, want all 0", led_pwm, busy, fast_pwm, fast_busy);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut.led_q !== 3'b000 || dut.u_ch0.level !== 8'd0 || dut.u_ch0.state !== ST_OFF) begin
      n_fail++;
      $display("FAIL reset_state: led_q=%b level=%0d state=%0d, want 0 0 OFF",
               dut.led_q, dut.u_ch0.level, dut.u_ch0.state);
    end
    do_reset(3'b000, 1'b1);
    for (int k = 1; k <= 300; k++) begin
      run_to(k);
      n_checks++;
      if ({led_pwm, busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_300 edge %0d: pwm=%b busy=%b, want 000 0", k, led_pwm, busy);
      end
    end
  endtask

  task automatic test_ramp_up;
    do_reset(3'b000, 1'b1);
    led_in = 3'b001;
    run_to(1);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_busy_e1: got %b want 0", busy);
    end
    run_to(2);
    n_checks++;
    if (busy !== 1'b1 || dut.u_ch0.state !== ST_UP) begin
      n_fail++;
      $display("FAIL ramp_busy_e2: busy=%b state=%0d, want 1 UP", busy, dut.u_ch0.state);
    end
    run_to(4);
    n_checks++;
    if (dut.u_ch0.level !== 8'd16) begin
      n_fail++;
      $display("FAIL ramp_first_tick: level=%0d want 16", dut.u_ch0.level);
    end
    run_to(5);
    n_checks++;
    if (led_pwm !== 3'b001) begin
      n_fail++;
      $display("FAIL ramp_pwm_e5: got %b want 001", led_pwm);
    end
    run_to(63);
    n_checks++;
    if (busy !== 1'b1 || dut.u_ch0.level !== 8'd240) begin
      n_fail++;
      $display("FAIL ramp_e63: busy=%b level=%0d, want 1 240", busy, dut.u_ch0.level);
    end
    run_to(64);
    n_checks++;
    if (busy !== 1'b0 || dut.u_ch0.level !== 8'd255 || dut.u_ch0.state !== ST_ON) begin
      n_fail++;
      $display("FAIL ramp_on_e64: busy=%b level=%0d state=%0d, want 0 255 ON",
               busy, dut.u_ch0.level, dut.u_ch0.state);
    end
    for (int k = 65; k <= 330; k++) begin
      run_to(k);
      n_checks++;
      if (led_pwm !== 3'b001 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL on_steady edge %0d: pwm=%b busy=%b, want 001 0", k, led_pwm, busy);
      end
    end
  endtask

  task automatic test_duty;
    int highs;
    do_reset(3'b000, 1'b1);
    led_in = 3'b001;
    run_to(256);
    n_checks++;
    if (dut_slow.u_ch0.level !== 8'd128) begin
      n_fail++;
      $display("FAIL duty_level: level=%0d want 128", dut_slow.u_ch0.level);
    end
    highs = 0;
    for (int k = 257; k <= 512; k++) begin
      run_to(k);
      if (slow_pwm[0]) highs++;
      if (k == 384) begin
        n_checks++;
        if (slow_pwm[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL duty_phase_384: got %b want 1", slow_pwm[0]);
        end
      end
      if (k == 385) begin
        n_checks++;
        if (slow_pwm[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL duty_phase_385: got %b want 0", slow_pwm[0]);
        end
      end
    end
    n_checks++;
    if (highs != 128) begin
      n_fail++;
      $display("FAIL duty_count: high %0d of 256, want 128", highs);
    end
    n_checks++;
    if (dut_slow.u_ch0.state !== ST_ON || dut_slow.u_ch0.level !== 8'd255) begin
      n_fail++;
      $display("FAIL duty_sat: state=%0d level=%0d, want ON 255",
               dut_slow.u_ch0.state, dut_slow.u_ch0.level);
    end
  endtask

  task automatic test_abort_up;
    do_reset(3'b000, 1'b1);
    led_in = 3'b001;
    run_to(22);
    n_checks++;
    if (dut.u_ch0.level !== 8'd80 || dut.u_ch0.state !== ST_UP) begin
      n_fail++;
      $display("FAIL abort_pre: level=%0d state=%0d, want 80 UP", dut.u_ch0.level, dut.u_ch0.state);
    end
    led_in = 3'b000;
    run_to(23);
    n_checks++;
    if (dut.u_ch0.state !== ST_UP || dut.u_ch0.level !== 8'd80) begin
      n_fail++;
      $display("FAIL abort_e23: state=%0d level=%0d, want UP 80", dut.u_ch0.state, dut.u_ch0.level);
    end
    run_to(24);
    n_checks++;
    if (dut.u_ch0.state !== ST_DOWN || dut.u_ch0.level !== 8'd80) begin
      n_fail++;
      $display("FAIL abort_priority: state=%0d level=%0d, want DOWN 80",
               dut.u_ch0.state, dut.u_ch0.level);
    end
    run_to(28);
    n_checks++;
    if (dut.u_ch0.level !== 8'd64) begin
      n_fail++;
      $display("FAIL abort_down_tick: level=%0d want 64", dut.u_ch0.level);
    end
    run_to(43);
    n_checks++;
    if (dut.u_ch0.level !== 8'd16 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_e43: level=%0d busy=%b, want 16 1", dut.u_ch0.level, busy);
    end
    run_to(44);
    n_checks++;
    if (dut.u_ch0.level !== 8'd0 || dut.u_ch0.state !== ST_OFF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_off: level=%0d state=%0d busy=%b, want 0 OFF 0",
               dut.u_ch0.level, dut.u_ch0.state, busy);
    end
  endtask

  task automatic test_freeze;
    do_reset(3'b000, 1'b1);
    led_in = 3'b001;
    run_to(10);
    en = 1'b0;
    run_to(11);
    n_checks++;
    if (led_pwm !== 3'b000) begin
      n_fail++;
      $display("FAIL freeze_pwm_off: got %b want 000", led_pwm);
    end
    for (int k = 12; k <= 60; k++) begin
      run_to(k);
      n_checks++;
      if ({led_pwm, busy, dut.u_ch0.level} !== {3'b000, 1'b1, 8'd32}) begin
        n_fail++;
        $display("FAIL freeze_hold edge %0d: pwm=%b busy=%b level=%0d, want 000 1 32",
                 k, led_pwm, busy, dut.u_ch0.level);
      end
    end
    en = 1'b1;
    run_to(61);
    n_checks++;
    if (dut.u_ch0.level !== 8'd32 || led_pwm !== 3'b001) begin
      n_fail++;
      $display("FAIL resume_e61: level=%0d pwm=%b, want 32 001", dut.u_ch0.level, led_pwm);
    end
    run_to(62);
    n_checks++;
    if (dut.u_ch0.level !== 8'd48) begin
      n_fail++;
      $display("FAIL resume_tick_phase: level=%0d want 48", dut.u_ch0.level);
    end
  endtask

  task automatic test_channels;
    do_reset(3'b000, 1'b1);
    led_in = 3'b010;
    run_to(64);
    n_checks++;
    if (busy !== 1'b0 || dut.u_ch1.level !== 8'd255 || dut.u_ch0.level !== 8'd0) begin
      n_fail++;
      $display("FAIL chan_ch1_on: busy=%b ch1=%0d ch0=%0d, want 0 255 0",
               busy, dut.u_ch1.level, dut.u_ch0.level);
    end
    run_to(66);
    n_checks++;
    if (led_pwm !== 3'b010) begin
      n_fail++;
      $display("FAIL chan_pwm_010: got %b want 010", led_pwm);
    end
    led_in = 3'b100;
    run_to(67);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL chan_busy_e67: got %b want 0", busy);
    end
    run_to(68);
    n_checks++;
    if (busy !== 1'b1 || dut.u_ch1.state !== ST_DOWN || dut.u_ch2.state !== ST_UP) begin
      n_fail++;
      $display("FAIL chan_swap: busy=%b ch1=%0d ch2=%0d, want 1 DOWN UP",
               busy, dut.u_ch1.state, dut.u_ch2.state);
    end
    run_to(72);
    n_checks++;
    if (dut.u_ch1.level !== 8'd239 || dut.u_ch2.level !== 8'd16) begin
      n_fail++;
      $display("FAIL chan_tick72: ch1=%0d ch2=%0d, want 239 16", dut.u_ch1.level, dut.u_ch2.level);
    end
    run_to(131);
    n_checks++;
    if (busy !== 1'b1 || dut.u_ch1.level !== 8'd15) begin
      n_fail++;
      $display("FAIL chan_e131: busy=%b ch1=%0d, want 1 15", busy, dut.u_ch1.level);
    end
    run_to(132);
    n_checks++;
    if (busy !== 1'b0 || dut.u_ch1.level !== 8'd0 || dut.u_ch2.level !== 8'd255) begin
      n_fail++;
      $display("FAIL chan_done: busy=%b ch1=%0d ch2=%0d, want 0 0 255",
               busy, dut.u_ch1.level, dut.u_ch2.level);
    end
    run_to(133);
    n_checks++;
    if (led_pwm !== 3'b100) begin
      n_fail++;
      $display("FAIL chan_pwm_100: got %b want 100", led_pwm);
    end
  endtask

  task automatic test_fast_async;
    do_reset(3'b000, 1'b1);
    led_in = 3'b111;
    run_to(2);
    n_checks++;
    if (fast_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fast_up: busy=%b want 1", fast_busy);
    end
    run_to(3);
    n_checks++;
    if (fast_busy !== 1'b0 || dut_fast.u_ch0.state !== ST_ON || dut_fast.u_ch2.level !== 8'd255) begin
      n_fail++;
      $display("FAIL fast_one_tick: busy=%b state=%0d level=%0d, want 0 ON 255",
               fast_busy, dut_fast.u_ch0.state, dut_fast.u_ch2.level);
    end
    run_to(4);
    n_checks++;
    if (fast_pwm !== 3'b111) begin
      n_fail++;
      $display("FAIL fast_pwm_on: got %b want 111", fast_pwm);
    end
    led_in = 3'b000;
    run_to(6);
    n_checks++;
    if (fast_busy !== 1'b1 || fast_pwm !== 3'b111 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fast_mid_down: fbusy=%b fpwm=%b busy=%b, want 1 111 1", fast_busy, fast_pwm, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fast_pwm, fast_busy, led_pwm, busy} !== 8'h00 || dut_fast.u_ch0.level !== 8'd0 ||
        dut.u_ch0.level !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: fpwm=%b fbusy=%b pwm=%b busy=%b flevel=%0d level=%0d, want all 0",
               fast_pwm, fast_busy, led_pwm, busy, dut_fast.u_ch0.level, dut.u_ch0.level);
    end
    led_in = 3'b111;
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    run_to(1);
    n_checks++;
    if (fast_busy !== 1'b0 || dut_fast.u_ch0.state !== ST_OFF) begin
      n_fail++;
      $display("FAIL post_reset_e1: busy=%b state=%0d, want 0 OFF", fast_busy, dut_fast.u_ch0.state);
    end
    run_to(2);
    n_checks++;
    if (fast_busy !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_reeval: fbusy=%b busy=%b, want 1 1", fast_busy, busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    edge_n   = 0;
    rst_n    = 1'b0;
    led_in   = 3'b000;
    en       = 1'b0;
    test_reset();
    test_ramp_up();
    test_duty();
    test_abort_up();
    test_freeze();
    test_channels();
    test_fast_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 4, meaning clock cycles per ramp tick (legal range 1..256).
REQ-002 SHALL have parameter STEP, default 16, meaning level increment/decrement per ramp tick (legal range 1..255).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port led_in  input  3  meaning per-channel on/off request from the upstream LED pattern stage; treated as a level.
REQ-006 SHALL have port en  input  1  meaning run enable; when 0, the block freezes.
REQ-007 SHALL have port led_pwm  output  3  meaning registered PWM drive per channel.
REQ-008 SHALL have port busy  output  1  meaning registered; 1 while any channel is in UP or DOWN.

Function
REQ-009 SHALL register led_in into led_q every cycle, independent of en; channel FSMs act on led_q only.
REQ-010 SHALL keep an 8-bit pwm_cnt that increments by 1 each cycle with en=1 and wraps 255->0.
REQ-011 SHALL keep a prescaler that counts 0..RAMP_DIV-1 with en=1; tick is asserted for one cycle when prescaler==RAMP_DIV-1, and the prescaler then returns to 0.
REQ-012 SHALL keep an 8-bit level and a state in {OFF, UP, ON, DOWN} per channel.
REQ-013 In OFF (level 0): led_q=1 -> UP on the next edge; otherwise hold.
REQ-014 In UP: on tick, level = min(level+STEP, 255); when the new level equals 255, state -> ON in the same edge.
REQ-015 In UP with led_q=0: state -> DOWN, level unchanged; led_q=0 takes priority over a coincident tick.
REQ-016 In ON (level 255): led_q=0 -> DOWN; otherwise hold.
REQ-017 In DOWN: on tick, level = max(level-STEP, 0); when the new level equals 0, state -> OFF in the same edge.
REQ-018 In DOWN with led_q=1: state -> UP, level unchanged; led_q=1 takes priority over a coincident tick.
REQ-019 SHALL compute arithmetic in 9 bits and saturate; level SHALL never wrap.
REQ-020 led_pwm[i] SHALL be registered as 1 when level==255, else (level > pwm_cnt); this gives one cycle of latency from level/pwm_cnt.
REQ-021 With en=0: pwm_cnt, prescaler, tick, states and levels SHALL hold; led_pwm SHALL be 0 from the next edge; busy SHALL still reflect state.
REQ-022 When en rises, operation SHALL resume from the held values with no reset of counters.
REQ-023 Channels SHALL be independent and share only pwm_cnt and tick.

Reset
REQ-024 While rst_n=0, the following SHALL be cleared asynchronously: led_q=0, pwm_cnt=0, prescaler=0, all levels=0, all states=OFF, led_pwm=0, busy=0.
REQ-025 Reset asserted mid-ramp SHALL abandon the ramp; after release, each channel SHALL start in OFF and re-evaluate led_q.

Structure
REQ-026 Package led_pwm_pkg SHALL hold the state enum (OFF, UP, ON, DOWN), PWM_W=8, and MAX_LEVEL=255.
REQ-027 Sub-module led_ramp_channel (FSM + level + PWM compare) SHALL be instantiated 3 times.
REQ-028 pwm_cnt and the prescaler SHALL live in the top module.

Verification
REQ-029 Reset with led_in=3'b000 and en=1 for 300 cycles -> led_pwm stays 000, busy stays 0.
REQ-030 Defaults, led_in 000->001 -> busy=1 two cycles later; ch0 reaches ON after 16 ticks (64 cycles) -> led_pwm[0] constant 1, busy=0.
REQ-031 Ch0 at level 128 (PWM steady) -> led_pwm[0] high exactly 128 of every 256 cycles.
REQ-032 Ch0 in UP at level 80, led_in[0] drops -> DOWN next edge with level 80, then 5 ticks -> OFF.
REQ-033 en=0 for 50 cycles mid-ramp -> led_pwm=000 and level unchanged; after en=1, the ramp continues from the same level and prescaler.
REQ-034 Parameters RAMP_DIV=1, STEP=255 -> OFF->ON in one tick; rst_n pulsed low mid-ramp -> all outputs 0 immediately (asynchronously).
